// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for a 5-stage F/D/E/M/W pipeline: operand forwarding,
// load-use bubbles, multi-cycle E freeze and branch flush.
module hazard_ctrl_mc #(
    parameter int unsigned AW        = 4,
    parameter int unsigned NSRC      = 2,
    parameter int unsigned LU_CYCLES = 1,
    parameter int unsigned MC_LAT    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NSRC*AW-1:0] RA_D,
    input  logic [NSRC*AW-1:0] RA_E,
    input  logic [AW-1:0]      WA3E,
    input  logic [AW-1:0]      WA3M,
    input  logic [AW-1:0]      WA3W,
    input  logic               RegWriteE,
    input  logic               RegWriteM,
    input  logic               RegWriteW,
    input  logic               MemtoRegE,
    input  logic               MultiCycleE,
    input  logic               BranchTakenE,
    output logic [NSRC*2-1:0]  ForwardE,
    output logic               StallF,
    output logic               StallD,
    output logic               StallE,
    output logic               FlushD,
    output logic               FlushE,
    output logic               FlushM,
    output logic               mc_busy
);

    localparam int unsigned LUW = (LU_CYCLES > 1) ? $clog2(LU_CYCLES) : 1;
    localparam int unsigned MCW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
    localparam logic [LUW-1:0] LU_LOAD = LUW'(LU_CYCLES - 1);
    localparam logic [MCW-1:0] MC_LOAD = MCW'((MC_LAT > 2) ? (MC_LAT - 2) : 0);
    localparam bit MC_EN   = (MC_LAT > 1);
    localparam bit MC_LONG = (MC_LAT > 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

    mc_state_e         state_q, state_d;
    logic [MCW-1:0]    mc_cnt_q, mc_cnt_d;
    logic [LUW-1:0]    lu_cnt_q, lu_cnt_d;

    logic [NSRC*2-1:0] fwd_c;
    logic              lu_hit_c;
    logic              stall_f_c, stall_d_c, stall_e_c;
    logic              flush_d_c, flush_e_c, flush_m_c, busy_c;

    // Per-slot forwarding select: M result beats W result.
    always_comb begin
        fwd_c = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (RegWriteM && (WA3M == RA_E[i*AW +: AW])) begin
                fwd_c[i*2 +: 2] = 2'b10;
            end else if (RegWriteW && (WA3W == RA_E[i*AW +: AW])) begin
                fwd_c[i*2 +: 2] = 2'b01;
            end
        end
    end

    // A load in E feeding any source of the instruction in D.
    always_comb begin
        lu_hit_c = 1'b0;
        for (int i = 0; i < int'(NSRC); i++) begin
            if (RA_D[i*AW +: AW] == WA3E) begin
                lu_hit_c = 1'b1;
            end
        end
        lu_hit_c = lu_hit_c & MemtoRegE & RegWriteE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mc_cnt_q <= '0;
            lu_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Busy cycles after the start cycle number MC_LAT-2, so E is frozen
    // for MC_LAT-1 cycles and the op leaves E after exactly MC_LAT cycles.
    always_comb begin
        state_d   = state_q;
        mc_cnt_d  = mc_cnt_q;
        lu_cnt_d  = lu_cnt_q;
        stall_f_c = 1'b0;
        stall_d_c = 1'b0;
        stall_e_c = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        flush_m_c = 1'b0;
        busy_c    = 1'b0;
        case (state_q)
            BUSY: begin
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                flush_m_c = 1'b1;
                busy_c    = 1'b1;
                if (mc_cnt_q <= MCW'(1)) begin
                    state_d  = IDLE;
                    mc_cnt_d = '0;
                end else begin
                    mc_cnt_d = mc_cnt_q - MCW'(1);
                end
            end
            IDLE: begin
                if (MultiCycleE && MC_EN) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                    if (MC_LONG) begin
                        state_d  = BUSY;
                        mc_cnt_d = MC_LOAD;
                    end
                end else if (BranchTakenE) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    lu_cnt_d  = '0;
                end else if (lu_hit_c) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    lu_cnt_d  = LU_LOAD;
                end else if (lu_cnt_q != '0) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    lu_cnt_d  = lu_cnt_q - LUW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                mc_cnt_d = '0;
            end
        endcase
    end

    // Reset dominates even the combinational outputs.
    assign ForwardE = reset_n ? fwd_c : '0;
    assign StallF   = reset_n & stall_f_c;
    assign StallD   = reset_n & stall_d_c;
    assign StallE   = reset_n & stall_e_c;
    assign FlushD   = reset_n & flush_d_c;
    assign FlushE   = reset_n & flush_e_c;
    assign FlushM   = reset_n & flush_m_c;
    assign mc_busy  = reset_n & busy_c;

endmodule
